// File: rtl/irrigation_actuator_seq_if.sv
// Request/relay bundle between the irrigation controller side and the actuator sequencer.
interface irrigation_actuator_seq_if;
  logic       bs_req;
  logic       vs_req;
  logic       err_clr;
  logic       pump_asp;
  logic       valve_got;
  logic       err_timeout;
  logic       busy;
  logic [2:0] state_o;

  modport master (
    output bs_req, vs_req, err_clr,
    input  pump_asp, valve_got, err_timeout, busy, state_o
  );

  modport slave (
    input  bs_req, vs_req, err_clr,
    output pump_asp, valve_got, err_timeout, busy, state_o
  );
endinterface

// File: rtl/irrigation_actuator_seq.sv
// Pump/valve relay sequencer: synchronise and debounce requests, keep actuators exclusive,
// enforce minimum on/off times and flag runs that exceed MAX_ON.
module irrigation_actuator_seq #(
  parameter int DEB_CYCLES = 4,
  parameter int MIN_ON     = 8,
  parameter int MIN_OFF    = 8,
  parameter int MAX_ON     = 1000,
  parameter int CNT_W      = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  irrigation_actuator_seq_if.slave        bus
);
  localparam int DEB_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ASP_ON   = 3'd1;
  localparam logic [2:0] GOT_ON   = 3'd2;
  localparam logic [2:0] COOLDOWN = 3'd3;
  localparam logic [2:0] FAULT    = 3'd4;

  // Channel 0 = sprinkler (bs), channel 1 = drip (vs)
  logic [1:0]            sync1, sync2, filt;
  logic [1:0][DEB_W-1:0] deb_cnt;
  logic [1:0]            req_raw;

  assign req_raw = {bus.vs_req, bus.bs_req};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      filt    <= '0;
      deb_cnt <= '0;
    end else begin
      sync1 <= req_raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
          filt[i]    <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic             bs_f, vs_f;
  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             run_max, run_min, off_done;

  assign bs_f     = filt[0];
  assign vs_f     = filt[1];
  assign run_max  = (cnt == CNT_W'(MAX_ON - 1));
  assign run_min  = (cnt >= CNT_W'(MIN_ON - 1));
  assign off_done = (cnt == CNT_W'(MIN_OFF - 1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (bs_f) state_nxt = ASP_ON;
                else if (vs_f) state_nxt = GOT_ON;
      ASP_ON:   if (run_max) state_nxt = FAULT;
                else if (!bs_f && run_min) state_nxt = COOLDOWN;
      GOT_ON:   if (run_max) state_nxt = FAULT;
                else if (!vs_f && run_min) state_nxt = COOLDOWN;
      COOLDOWN: if (off_done) state_nxt = IDLE;
      FAULT:    if (bus.err_clr) state_nxt = COOLDOWN;
      default:  state_nxt = IDLE;
    endcase
  end

  // Counter restarts on every state entry and only runs in timed states
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        cnt <= '0;
      else if (state == ASP_ON || state == GOT_ON || state == COOLDOWN)
        cnt <= cnt + 1'b1;
    end
  end

  // Moore decode so relays drop the instant reset asserts
  assign bus.pump_asp    = (state == ASP_ON);
  assign bus.valve_got   = (state == GOT_ON);
  assign bus.err_timeout = (state == FAULT);
  assign bus.busy        = (state != IDLE);
  assign bus.state_o     = state;
endmodule
